// File: rtl/data_register_pkg.sv
// rtl/data_register_pkg.sv - shared constants and reset-value sizing helper for data_register
package data_register_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int MAX_WIDTH     = 64;

  // Keeps only the low 'width' bits; upper bits are zeroed, never sign-extended.
  function automatic logic [MAX_WIDTH-1:0] fit_reset_value(input logic [MAX_WIDTH-1:0] value,
                                                           input int width);
    if (width >= MAX_WIDTH) return value;
    return value & ~({MAX_WIDTH{1'b1}} << width);
  endfunction

endpackage

// File: rtl/data_register.sv
// rtl/data_register.sv - parameterised holding register with clear, load enable, valid and changed pulse
module data_register
  import data_register_pkg::*;
#(
  parameter int                   WIDTH       = DEFAULT_WIDTH,
  parameter logic [MAX_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             changed
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(fit_reset_value(RESET_VALUE, WIDTH));

  // Priority rst > clear > en > hold; changed compares against the value being replaced.
  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= RST_VAL;
      valid   <= 1'b0;
      changed <= 1'b0;
    end else if (clear) begin
      out     <= RST_VAL;
      valid   <= 1'b0;
      changed <= (out != RST_VAL);
    end else if (en) begin
      out     <= in;
      valid   <= 1'b1;
      changed <= (in != out);
    end else begin
      changed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_register.sv
// tb/tb_data_register.sv - scoreboard bench for data_register at WIDTH=4 and WIDTH=8/RESET_VALUE=8'hA5
module tb_data_register;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clear = 1'b0;
  logic       en = 1'b0;
  logic [3:0] in4 = '0;
  logic [7:0] in8 = '0;
  logic [3:0] out4;
  logic [7:0] out8;
  logic       valid4, changed4, valid8, changed8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         sel;
    logic [7:0] out;
    logic       valid;
    logic       changed;
    string      name;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  data_register dut4 (
    .clk(clk), .rst(rst), .clear(clear), .en(en),
    .in(in4), .out(out4), .valid(valid4), .changed(changed4)
  );

  data_register #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
    .clk(clk), .rst(rst), .clear(clear), .en(en),
    .in(in8), .out(out8), .valid(valid8), .changed(changed8)
  );

  // Monitor: one expectation is consumed per edge, sampled just after the edge.
  always begin
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      logic [7:0] a_out;
      logic       a_valid, a_changed;
      e = sb.pop_front();
      a_out     = e.sel ? out8 : {4'b0000, out4};
      a_valid   = e.sel ? valid8 : valid4;
      a_changed = e.sel ? changed8 : changed4;
      checks++;
      if (a_out !== e.out || a_valid !== e.valid || a_changed !== e.changed) begin
        errors++;
        $display("FAIL %s: got out=%h valid=%b changed=%b, expected out=%h valid=%b changed=%b",
                 e.name, a_out, a_valid, a_changed, e.out, e.valid, e.changed);
      end
    end
  end

  task automatic step(input bit s, input logic r, input logic c, input logic e,
                      input logic [7:0] d, input logic [7:0] eo, input logic ev,
                      input logic ec, input string name);
    exp_t x;
    @(negedge clk);
    rst = r; clear = c; en = e;
    if (s) in8 = d; else in4 = d[3:0];
    x.sel = s; x.out = eo; x.valid = ev; x.changed = ec; x.name = name;
    sb.push_back(x);
    @(posedge clk);
  endtask

  initial begin
    // reset, two edges, with in all ones
    step(0, 1, 0, 1, 8'h0F, 8'h00, 0, 0, "reset_0");
    step(0, 1, 0, 1, 8'h0F, 8'h00, 0, 0, "reset_1");
    step(0, 0, 0, 1, 8'h00, 8'h00, 1, 0, "post_reset_load0");

    // load sequence
    step(0, 0, 0, 1, 8'h0A, 8'h0A, 1, 1, "load_a_first");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8'h0A, 8'h0A, 1, 0, "load_a_repeat");
    step(0, 0, 0, 1, 8'h0C, 8'h0C, 1, 1, "load_c_first");
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 8'h0C, 8'h0C, 1, 0, "load_c_repeat");

    // hold with toggling and unknown input
    step(0, 0, 0, 1, 8'h0A, 8'h0A, 1, 1, "reload_a");
    step(0, 0, 0, 0, 8'h05, 8'h0A, 1, 0, "hold_in5");
    step(0, 0, 0, 0, 8'h0F, 8'h0A, 1, 0, "hold_inf");
    step(0, 0, 0, 0, 8'hxx, 8'h0A, 1, 0, "hold_inx");

    // clear beats enable
    step(0, 0, 0, 1, 8'h0C, 8'h0C, 1, 1, "reload_c");
    step(0, 0, 1, 1, 8'h06, 8'h00, 0, 1, "clear_over_en");
    step(0, 0, 0, 1, 8'h06, 8'h06, 1, 1, "load_after_clear");
    step(0, 0, 1, 0, 8'h06, 8'h00, 0, 1, "clear_nonzero");
    step(0, 0, 1, 0, 8'h06, 8'h00, 0, 0, "clear_at_reset_value");

    // reset beats clear mid-stream
    step(0, 0, 0, 1, 8'h09, 8'h09, 1, 1, "load_9");
    step(0, 1, 1, 1, 8'h09, 8'h00, 0, 0, "rst_over_clear");

    // WIDTH=8, RESET_VALUE=8'hA5
    step(1, 1, 0, 1, 8'h3C, 8'hA5, 0, 0, "w8_reset");
    step(1, 0, 0, 1, 8'h3C, 8'h3C, 1, 1, "w8_load_3c");
    step(1, 0, 0, 1, 8'h3C, 8'h3C, 1, 0, "w8_load_3c_again");
    step(1, 0, 1, 1, 8'h3C, 8'hA5, 0, 1, "w8_clear");
    step(1, 0, 0, 1, 8'hA5, 8'hA5, 1, 0, "w8_load_reset_value");

    @(negedge clk);
    en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
